fake_n64_controller_tx: RTL
===========================

// Module: fake_n64_controller_tx
// PURPOSE
// Response transmitter of the fake N64 controller; sits directly downstream of the receive stage.
// - On each toggle of tx_handoff, serialises the reply for the latched cmd onto the joybus line, MSB first.
//   Encoding: 4 us bit cells, then a controller stop bit.
// - Drives cur_operation high for the whole reply so the receive-side sampler ignores our own traffic.
// PARAMETERS
// CLKS_PER_US    16  clk cycles per microsecond (>=2)
// TURNAROUND_US  2   idle time between handoff detect and first bit cell
// INFO_RESP      24'h050002  reply word for INFO/RESET
// PORTS
// clk            in   1   system clock
// reset          in   1   synchronous, active-high reset
// tx_handoff     in   1   toggle from rx stage (asynchronous to clk); each edge = one request
// cmd            in   8   command byte from rx stage; stable from before toggle until next toggle
// buttons        in   32  live controller state {A,B,Z,S,dU,dD,dL,dR,0,0,L,R,cU,cD,cL,cR,X[7:0],Y[7:0]}
// data_tx        out  1   line value; 0 = pull low, 1 = release (idle high)
// cur_operation  out  1   1 = transmitting (tx owns line), 0 = receiving
// BEHAVIOUR
// Reset values:
// - data_tx=1, cur_operation=0, state=IDLE.
// - Handoff sync flops and the edge-reference flop load the current sync value, so no spurious request.
// Handoff detect:
// - tx_handoff passes through a 2-flop synchroniser, then a third flop.
// - req = sync2 ^ sync3.
// - Detect occurs 3 clk after the toggle, +/-1 for metastability.
// - A req seen outside IDLE is discarded: the edge reference always updates, so nothing is queued.
// Command decode, on the req cycle in IDLE:
// - 8'h00 and 8'hff: shift_reg[31:8] <= INFO_RESP, nbits=24.
// - 8'h01: shift_reg <= buttons, sampled on this cycle only; nbits=32.
// - Any other value (incl. 8'h02, 8'h03): no reply; stay IDLE; cur_operation stays 0.
// States:
// - IDLE -> TURN on a valid req. cur_operation <= 1 on that same edge.
// - TURN: data_tx=1 for TURNAROUND_US*CLKS_PER_US cycles, then -> LOW.
// - LOW: data_tx=0 for 1 us if shift_reg[31]=1, or 3 us if 0; then -> HIGH.
// - HIGH: data_tx=1 for the remainder of the 4 us cell (3 us or 1 us).
//   - At cell end, shift left and decrement nbits.
//   - Go to LOW if nbits != 0, else -> STOP.
// - STOP: data_tx=0 for 2 us, then data_tx=1 and -> DONE.
// - DONE: 1 cycle. cur_operation <= 0, then -> IDLE.
// Counters:
// - Timer width is clog2(4*CLKS_PER_US). It is reloaded, never wrapped.
// - Bit counter is 6 bits; a zero-length reply is impossible.
// Timing:
// - Each bit cell is exactly 4*CLKS_PER_US cycles.
// - Total reply = TURN + nbits*4us + 2us + 1 cycle.
// Other rules:
// - cmd and buttons changes after the decode cycle do not affect the reply.
// - Reset mid-operation: on the next edge data_tx=1, cur_operation=0, state IDLE.
//   - A partial word is abandoned, with no stop bit.
//   - A pending req is dropped.
// - All outputs are registered. data_tx is never low in IDLE, TURN or DONE.
// TESTING (bench: CLKS_PER_US=4, TURNAROUND_US=2)
// 1. Reset for 3 cycles, no handoff -> data_tx=1 and cur_operation=0 throughout; 100 idle cycles with no activity.
// 2. cmd=8'h00, toggle handoff:
//    - cur_operation rises 3 cycles after the toggle.
//    - 8 cycles later, 24 cells appear carrying 0x050002; first cell is 12 low + 4 high.
//    - Stop is 8 low, then release; cur_operation falls 1 cycle later.
// 3. cmd=8'h01, buttons=32'h80000001, then buttons=0 at the first cell:
//    - Cell0 is 4 low + 12 high; cell31 is 4 low; cells 1-30 are 12 low.
// 4. cmd=8'h02, toggle -> data_tx stays 1 and cur_operation stays 0 for 300 cycles.
// 5. Second toggle mid-reply (cmd=8'hff) -> exactly one 24-bit reply plus stop; nothing follows.
// 6. Reset asserted in cell 5 of a button reply:
//    - data_tx=1 and cur_operation=0 on the next edge.
//    - A fresh toggle afterward yields a complete, correct reply.

Source files
------------

// File: rtl/fake_n64_controller_tx.sv
// Joybus reply transmitter for the fake N64 controller.
// A toggle on tx_handoff (from the receive stage, async to clk) requests a
// reply to the latched cmd byte. The reply is sent MSB first in 4 us cells
// and followed by a controller stop bit. cur_operation is held high for
// the whole reply so that the receive sampler ignores our own traffic.
//
// state | meaning
// IDLE  | waiting for a handoff edge; line released
// TURN  | turnaround gap before the first cell; line released
// LOW   | low phase of a data cell (1 us for a '1', 3 us for a '0')
// HIGH  | high remainder of the data cell
// STOP  | controller stop bit, 2 us low
// DONE  | line released, drop cur_operation on exit
module fake_n64_controller_tx #(
   parameter int          CLKS_PER_US   = 16,
   parameter int          TURNAROUND_US = 2,
   parameter logic [23:0] INFO_RESP     = 24'h050002
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tx_handoff,
   input  logic [7:0]  cmd,
   input  logic [31:0] buttons,
   output logic        data_tx,
   output logic        cur_operation
);

   localparam int TW = $clog2(4*CLKS_PER_US);
   localparam logic [TW-1:0] T_1US  = TW'(CLKS_PER_US - 1);
   localparam logic [TW-1:0] T_2US  = TW'(2*CLKS_PER_US - 1);
   localparam logic [TW-1:0] T_3US  = TW'(3*CLKS_PER_US - 1);
   localparam logic [TW-1:0] T_TURN = TW'(TURNAROUND_US*CLKS_PER_US - 1);

   typedef enum logic [2:0] {IDLE, TURN, LOW, HIGH, STOP, DONE} state_t;

   state_t        state, state_nxt;
   logic [TW-1:0] timer, timer_nxt;
   logic [31:0]   shift_reg, shift_nxt;
   logic [5:0]    nbits, nbits_nxt;
   logic          sync1, sync2, sync3;
   logic          req;

   // Synchronise the handoff toggle; the third flop is the edge reference.
   // On reset all three settle to the current level so no edge is seen.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= tx_handoff;
         sync2 <= sync1;
         sync3 <= sync1;
      end else begin
         sync1 <= tx_handoff;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   // The reference always follows, so an edge outside IDLE is simply lost.
   assign req = sync2 ^ sync3;

   // Next-state, cell timing and shift logic.
   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      shift_nxt = shift_reg;
      nbits_nxt = nbits;
      case (state)
         IDLE: begin
            if (req) begin
               if (cmd == 8'h00 || cmd == 8'hff) begin
                  shift_nxt = {INFO_RESP, 8'h00};
                  nbits_nxt = 6'd24;
                  timer_nxt = T_TURN;
                  state_nxt = TURN;
               end else if (cmd == 8'h01) begin
                  shift_nxt = buttons;
                  nbits_nxt = 6'd32;
                  timer_nxt = T_TURN;
                  state_nxt = TURN;
               end
            end
         end
         TURN: begin
            if (timer == '0) begin
               timer_nxt = shift_reg[31] ? T_1US : T_3US;
               state_nxt = LOW;
            end else begin
               timer_nxt = timer - 1'b1;
            end
         end
         LOW: begin
            if (timer == '0) begin
               timer_nxt = shift_reg[31] ? T_3US : T_1US;
               state_nxt = HIGH;
            end else begin
               timer_nxt = timer - 1'b1;
            end
         end
         HIGH: begin
            if (timer == '0) begin
               shift_nxt = {shift_reg[30:0], 1'b0};
               nbits_nxt = nbits - 6'd1;
               if (nbits == 6'd1) begin
                  timer_nxt = T_2US;
                  state_nxt = STOP;
               end else begin
                  // shift_reg[30] becomes the MSB of the next cell
                  timer_nxt = shift_reg[30] ? T_1US : T_3US;
                  state_nxt = LOW;
               end
            end else begin
               timer_nxt = timer - 1'b1;
            end
         end
         STOP: begin
            if (timer == '0) begin
               state_nxt = DONE;
            end else begin
               timer_nxt = timer - 1'b1;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State and registered outputs; outputs are decoded from the next state
   // so they line up with the state they belong to.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         timer         <= '0;
         shift_reg     <= '0;
         nbits         <= '0;
         data_tx       <= 1'b1;
         cur_operation <= 1'b0;
      end else begin
         state         <= state_nxt;
         timer         <= timer_nxt;
         shift_reg     <= shift_nxt;
         nbits         <= nbits_nxt;
         data_tx       <= !(state_nxt == LOW || state_nxt == STOP);
         cur_operation <= (state_nxt != IDLE);
      end
   end

endmodule
